// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator and its consumers.
// Holds the pixel width default, the window tap count and the window element index.
package window_gen_3x3_pkg;

  localparam int PIX_WIDTH = 8;
  localparam int WIN_TAPS  = 3;

  // Flat index of window element (r,c); r=0 is the top row, c=2 the newest column.
  function automatic int idx(input int r, input int c);
    return WIN_TAPS * r + c;
  endfunction

endpackage

// File: rtl/window_gen_3x3_row_shift.sv
// One window row: a 3-deep WIDTH-bit shift register. Element 2 receives the
// newest tap, element 0 holds the oldest. Packed with element c at [c*WIDTH +: WIDTH].
module win_row_shift
  import window_gen_3x3_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [WIDTH-1:0]          tap_i,
  output logic [WIN_TAPS*WIDTH-1:0] row_o
);

  logic [WIN_TAPS*WIDTH-1:0] sh_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (en_i) begin
      sh_q <= {tap_i, sh_q[WIN_TAPS*WIDTH-1:WIDTH]};
    end
  end

  assign row_o = sh_q;

endmodule

// File: rtl/window_gen_3x3.sv
// Sliding 3x3 window generator fed by two chained line buffers.
// Define WIN_STRIDE2_EN to emit only stride-2 windows (even column start, even row).
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int WIDTH      = PIX_WIDTH,
  parameter int IMG_WIDTH  = 482,
  parameter int IMG_HEIGHT = 482
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din_top,
  input  logic [WIDTH-1:0]          din_mid,
  input  logic [WIDTH-1:0]          din_bot,
  input  logic                      valid_in,
  output logic [9*WIDTH-1:0]        win_out,
  output logic                      valid_out,
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 3);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          frame_q, frame_d;
  logic          col_last, row_last, win_ok;

  logic [WIDTH-1:0]          taps [WIN_TAPS];
  logic [WIN_TAPS*WIDTH-1:0] rows [WIN_TAPS];

  assign taps[0] = din_top;
  assign taps[1] = din_mid;
  assign taps[2] = din_bot;

  for (genvar r = 0; r < WIN_TAPS; r++) begin : g_row
    win_row_shift #(.WIDTH(WIDTH)) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (valid_in),
      .tap_i (taps[r]),
      .row_o (rows[r])
    );
    for (genvar c = 0; c < WIN_TAPS; c++) begin : g_col
      assign win_out[idx(r, c)*WIDTH +: WIDTH] = rows[r][c*WIDTH +: WIDTH];
    end
  end

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Columns 0 and 1 only prime the shift registers, so windows never span two rows.
`ifdef WIN_STRIDE2_EN
  assign win_ok = (col_q >= CW'(2)) && !col_q[0] && !row_q[0];
`else
  assign win_ok = (col_q >= CW'(2));
`endif

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    frame_d = 1'b0;
    if (valid_in) begin
      col_d   = col_last ? '0 : col_q + CW'(1);
      valid_d = win_ok;
      frame_d = col_last && row_last;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: stimulus pushes expected windows,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_window_gen_3x3;

  localparam int W = 8;
`ifdef WIN_STRIDE2_EN
  localparam int IW = 7;
  localparam int IH = 5;
`else
  localparam int IW = 5;
  localparam int IH = 4;
`endif
  localparam int EXP_PULSES = 6;
  localparam logic [9*W-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  typedef struct {
    logic [9*W-1:0] win;
    logic           fd;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din_top = '0, din_mid = '0, din_bot = '0;
  logic           valid_in = 1'b0;
  logic [9*W-1:0] win_out;
  logic           valid_out, frame_done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   frames = 0;
  bit   toggle_mode = 1'b0;
  logic prev_valid = 1'b0;

  window_gen_3x3 #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_top    (din_top),
    .din_mid    (din_mid),
    .din_bot    (din_bot),
    .valid_in   (valid_in),
    .win_out    (win_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int row, input int col);
    return W'(row * 16 + col);
  endfunction

  function automatic logic [9*W-1:0] exp_win(input int orow, input int c);
    logic [9*W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(3*r+k)*W +: W] = pix(orow + r, c - 2 + k);
    return w;
  endfunction

  function automatic bit want(input int orow, input int c);
`ifdef WIN_STRIDE2_EN
    return (c >= 2) && (c % 2 == 0) && (orow % 2 == 0);
`else
    return (c >= 2);
`endif
  endfunction

  task automatic drive_taps(input int orow, input int c);
    din_top  = pix(orow, c);
    din_mid  = pix(orow + 1, c);
    din_bot  = pix(orow + 2, c);
    valid_in = 1'b1;
  endtask

  task automatic beat(input int orow, input int c, input bit expect_out);
    exp_t e;
    drive_taps(orow, c);
    if (expect_out) begin
      e.win = exp_win(orow, c);
      e.fd  = (orow == IH - 3) && (c == IW - 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    din_top  = 8'hEE;
    din_mid  = 8'hEE;
    din_bot  = 8'hEE;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit toggle, input bit first_chk);
    pulses = 0;
    frames = 0;
    for (int r = 0; r <= IH - 3; r++) begin
      for (int c = 0; c < IW; c++) begin
        beat(r, c, want(r, c));
        if (first_chk && r == 0 && c == 2) check("first_window", win_out, FIRST_WIN);
        if (toggle) idle();
      end
    end
    idle();
    idle();
    check("frame_pulses", pulses, EXP_PULSES);
    check("frame_done_count", frames, 1);
  endtask

  // Monitor: compares each presented window against the head of the scoreboard.
  always @(negedge clk) begin
    if (toggle_mode && valid_out) check("toggle_no_back_to_back", prev_valid, 1'b0);
    if (valid_out) begin
      pulses++;
      if (frame_done) frames++;
      if (sb.size() == 0) begin
        check("unexpected_window", win_out, '0);
        check("unexpected_valid", valid_out, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("window", win_out, e.win);
        check("frame_done", frame_done, e.fd);
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", frame_done, 1'b0);
    end
    prev_valid = valid_out;
  end

  initial begin
    #3;
    check("reset_valid_out", valid_out, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_win_out", win_out, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("idle_valid_out", valid_out, 1'b0);

    // Continuous frame, then a second frame to show restart at row 0.
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);

    // valid_in toggled every cycle.
    toggle_mode = 1'b1;
    run_frame(1'b1, 1'b0);
    toggle_mode = 1'b0;

    // Mid-row reset with the c=3 beat captured and its window on the outputs.
    for (int c = 0; c < 3; c++) beat(0, c, want(0, c));
    drive_taps(0, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    check("async_reset_valid_out", valid_out, 1'b0);
    check("async_reset_frame_done", frame_done, 1'b0);
    check("async_reset_win_out", win_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    beat(0, 0, 1'b0);
    check("post_reset_c0_no_window", valid_out, 1'b0);
    beat(0, 1, 1'b0);
    check("post_reset_c1_no_window", valid_out, 1'b0);
    pulses = 0;
    frames = 0;
    for (int r = 0; r <= IH - 3; r++)
      for (int c = (r == 0) ? 2 : 0; c < IW; c++) begin
        beat(r, c, want(r, c));
        if (r == 0 && c == 2) check("post_reset_first_window", win_out, FIRST_WIN);
      end
    idle();
    idle();
    check("post_reset_pulses", pulses, EXP_PULSES);
    check("post_reset_frames", frames, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Sliding 3×3 window generator that sits directly downstream of the two chained line-buffer stages in the convolution front end. Each valid beat it takes one column of three vertically aligned pixels: the current row plus the one-line and two-line delayed rows. It shifts that column into a 3×3 register window and presents the full window to the systolic-array feeder. Column and row counters suppress windows that would straddle a row boundary and mark the end of each frame.

## Interface
Parameters:
- WIDTH, 8, pixel bit width
- IMG_WIDTH, 482, pixels per row, including padding columns
- IMG_HEIGHT, 482, rows per frame, including padding rows

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- din_top  input  WIDTH  pixel from two rows above (output of second line buffer)
- din_mid  input  WIDTH  pixel from one row above (output of first line buffer)
- din_bot  input  WIDTH  current-row pixel
- valid_in  input  1  all three taps valid this cycle (second line buffer's valid_out)
- win_out  output  9*WIDTH  window; element (r,c) at [(3*r+c)*WIDTH +: WIDTH], r=0 top, c=2 newest column
- valid_out  output  1  win_out holds a complete in-row window
- frame_done  output  1  one-cycle pulse coincident with the last window beat of a frame

## Operation
- Window shift, on each valid_in beat, for each row r: w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=tap. Taps: r0=din_top, r1=din_mid, r2=din_bot.
- valid_in low: window, counters and outputs hold, except that valid_out and frame_done drive 0.
- col_cnt, width $clog2(IMG_WIDTH):
  - increments per beat
  - at IMG_WIDTH-1, the next beat loads 0
- row_cnt, width $clog2(IMG_HEIGHT):
  - counts output rows 0..IMG_HEIGHT-3
  - increments on the beat where col_cnt==IMG_WIDTH-1
  - wraps to 0 after IMG_HEIGHT-3
- Window validity, on a beat with pre-update column c: valid when c>=2. The window then covers columns c-2..c. Beats at c=0,1 only prime the shift registers, so windows never wrap across rows.
- frame_done asserts on the beat with col_cnt==IMG_WIDTH-1 and row_cnt==IMG_HEIGHT-3.
- No arithmetic on pixel data. Data passes through unmodified.

## Timing
- Reset values: win_out=0, valid_out=0, frame_done=0, col_cnt=0, row_cnt=0.
- Latency: 1 cycle. valid_out and frame_done are registered and appear the cycle after the qualifying valid_in beat, alongside the updated win_out.
- There is no backpressure. The consumer must accept every valid_out cycle.
- Back-to-back valid_in gives one window per cycle. Gaps of any length are tolerated without losing alignment.
- Reset mid-frame clears the counters. The next valid_in is treated as column 0, row 0.
- Row wrap and frame wrap occur on the same edge as the last beat. The next beat starts column 0 with no dead cycle.

## Configuration
- WIN_STRIDE2_EN defined:
  - valid_out is additionally gated to windows with (c-2) even and row_cnt even, giving stride-2 output
  - frame_done timing is unchanged
  - counters and shifting are unchanged
- WIN_STRIDE2_EN undefined: every in-row window is emitted (stride 1).

## Structure
- Shared package holds:
  - pixel width default
  - window tap count (3)
  - the window element index function idx(r,c)=3*r+c, shared with the systolic-array feeder
- Sub-module win_row_shift: one 3-deep WIDTH-bit shift register with enable, instantiated three times.
- Counters and valid/frame logic stay in the top module.

## Test plan
Unless stated otherwise, use IMG_WIDTH=5, IMG_HEIGHT=4, and drive pixels with value row*16+col on each tap.
- Continuous valid_in, row 0 taps: first valid_out on the cycle after beat c=2, with win_out rows = {0x00,0x01,0x02},{0x10,0x11,0x12},{0x20,0x21,0x22}. Three windows per row, no window at c=0,1.
- Row boundary: the beat after c=4 is c=0. valid_out is low for the two following beats, and no window mixes columns 3,4 with columns 0 of the next row.
- Full frame: exactly 6 valid_out pulses. frame_done is high only with the 6th. The next frame restarts at row_cnt=0.
- valid_in toggled 1/0 every cycle: same 6 windows in the same order, valid_out never high in consecutive cycles.
- Assert rst_n low mid-row, at c=3: all outputs go 0 asynchronously. After release, the first window appears only after three new beats.
- WIN_STRIDE2_EN defined, IMG_WIDTH=7, IMG_HEIGHT=5: windows at c=2,4,6 on rows 0 and 2 only, 6 pulses total, frame_done on the last beat of row 2.
